// File: rtl/volt_uart_pkg.sv
// volt_uart_pkg: shared state types, ASCII constants and helpers for the
// voltage UART reporter. Optional build macro: VOLT_UART_PARITY_EN adds an
// even-parity bit-time after the data bits of every byte.
package volt_uart_pkg;

    localparam int FRAME_LEN = 9;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_V     = 8'h56;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_QMARK = 8'h3F;

    // Record sequencer: waits for a tick, presents a byte, waits for it to go out.
    typedef enum logic [1:0] {
        REC_IDLE,
        REC_LOAD,
        REC_SEND
    } rec_state_t;

    // Byte serialiser line states.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef VOLT_UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    // One BCD digit to its ASCII character; anything above 9 is shown as '?'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
        return (nib > 4'd9) ? ASC_QMARK : (ASC_ZERO + {4'd0, nib});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte per valid/ready handshake as
// start, 8 data bits LSB first, [even parity when VOLT_UART_PARITY_EN], stop.
// Each bit-time lasts BAUD_DIV clocks. The line output is registered so it
// changes on the edge that enters a bit. done pulses (combinationally) in the
// last clock of the stop bit so the caller can hand over the next byte with
// no idle gap beyond its own load cycle.
module uart_tx_byte
    import volt_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    tx_state_t     state, state_d;
    logic [CW-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic          tx_d;
    logic          bit_last;

    assign bit_last = (baud_cnt == CW'(BAUD_DIV - 1));
    assign ready    = (state == TX_IDLE);

    // Next-state and next line level for the bit sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        data_d     = data_q;
        tx_d       = tx;
        done       = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (valid) begin
                    state_d    = TX_START;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    data_d     = data;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                baud_cnt_d = baud_cnt + 1'b1;
                if (bit_last) begin
                    state_d    = TX_DATA;
                    baud_cnt_d = '0;
                    tx_d       = data_q[0];
                end
            end
            TX_DATA: begin
                baud_cnt_d = baud_cnt + 1'b1;
                if (bit_last) begin
                    baud_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
`ifdef VOLT_UART_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        tx_d      = data_q[bit_idx + 3'd1];
                    end
                end
            end
`ifdef VOLT_UART_PARITY_EN
            TX_PARITY: begin
                baud_cnt_d = baud_cnt + 1'b1;
                if (bit_last) begin
                    state_d    = TX_STOP;
                    baud_cnt_d = '0;
                    tx_d       = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                baud_cnt_d = baud_cnt + 1'b1;
                if (bit_last) begin
                    state_d    = TX_IDLE;
                    baud_cnt_d = '0;
                    done       = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; the line idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            data_q   <= data_d;
            tx       <= tx_d;
        end
    end

endmodule

// File: rtl/volt_uart_report.sv
// volt_uart_report: every REPORT_CYCLES clocks (when enabled and idle)
// snapshots the BCD voltage and sign and sends the 9-byte record
// "<sign>D.DDDV\r\n" over a UART. Optional build macro VOLT_UART_PARITY_EN
// (handled inside uart_tx_byte) adds even parity to each byte.
module volt_uart_report
    import volt_uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int REPORT_CYCLES = 5_000_000
) (
    input  logic        ad_clk,
    input  logic        rst_n,
    input  logic [19:0] ch1_dec,
    input  logic [7:0]  ch1_sig,
    input  logic        report_en,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int PW       = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;

    logic [PW-1:0] period_cnt;
    logic          tick;
    rec_state_t    state, state_d;
    logic [3:0]    idx, idx_d;
    logic [15:0]   snap_dec;
    logic [7:0]    snap_sig;
    logic          snap_load;
    logic          frame_done_d;
    logic [7:0]    byte_data;
    logic          byte_valid, byte_ready, byte_done;
    logic          unused_dec_hi;

    // Only four digits are reported; the top BCD digit is deliberately ignored.
    assign unused_dec_hi = ^ch1_dec[19:16];

    assign tick = (period_cnt == PW'(REPORT_CYCLES - 1));

    // Free-running report period counter, independent of transmitter activity.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n)    period_cnt <= '0;
        else if (tick) period_cnt <= '0;
        else           period_cnt <= period_cnt + 1'b1;
    end

    // Snapshot taken at frame start so mid-frame input changes cannot tear the record.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_dec <= '0;
            snap_sig <= '0;
        end else if (snap_load) begin
            snap_dec <= ch1_dec[15:0];
            snap_sig <= ch1_sig;
        end
    end

    // Record byte selection from the snapshot.
    always_comb begin
        byte_data = ASC_QMARK;
        case (idx)
            4'd0:    byte_data = snap_sig;
            4'd1:    byte_data = bcd_to_ascii(snap_dec[15:12]);
            4'd2:    byte_data = ASC_DOT;
            4'd3:    byte_data = bcd_to_ascii(snap_dec[11:8]);
            4'd4:    byte_data = bcd_to_ascii(snap_dec[7:4]);
            4'd5:    byte_data = bcd_to_ascii(snap_dec[3:0]);
            4'd6:    byte_data = ASC_V;
            4'd7:    byte_data = ASC_CR;
            4'd8:    byte_data = ASC_LF;
            default: byte_data = ASC_QMARK;
        endcase
    end

    // Record sequencing: ticks that arrive while busy are simply dropped.
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        snap_load    = 1'b0;
        byte_valid   = 1'b0;
        frame_done_d = 1'b0;
        case (state)
            REC_IDLE: begin
                if (tick && report_en) begin
                    state_d   = REC_LOAD;
                    idx_d     = '0;
                    snap_load = 1'b1;
                end
            end
            REC_LOAD: begin
                byte_valid = 1'b1;
                if (byte_ready) state_d = REC_SEND;
            end
            REC_SEND: begin
                if (byte_done) begin
                    if (idx < 4'(FRAME_LEN - 1)) begin
                        idx_d   = idx + 4'd1;
                        state_d = REC_LOAD;
                    end else begin
                        state_d      = REC_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = REC_IDLE;
        endcase
    end

    // Record state register; frame_done is registered so it aligns with busy falling.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REC_IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            frame_done <= frame_done_d;
        end
    end

    assign busy = (state != REC_IDLE);

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (ad_clk),
        .rst_n (rst_n),
        .data  (byte_data),
        .valid (byte_valid),
        .ready (byte_ready),
        .done  (byte_done),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_volt_uart_report.sv
// tb_volt_uart_report: directed bench for volt_uart_report with a byte
// scoreboard fed from literal expected records and a mid-bit UART sampler.
// Define VOLT_UART_PARITY_EN for both bench and RTL to exercise parity.
module tb_volt_uart_report;

    localparam int CLK_FREQ      = 1_000_000;
    localparam int BAUD          = 100_000;
    localparam int REPORT_CYCLES = 2000;
    localparam int BD            = CLK_FREQ / BAUD;
`ifdef VOLT_UART_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int BYTE_CYC   = BITS * BD + 1;
    localparam int WAIT_LIMIT = 2 * REPORT_CYCLES + 100;

    logic        ad_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [19:0] ch1_dec = '0;
    logic [7:0]  ch1_sig = 8'd43;
    logic        report_en = 1'b0;
    logic        uart_tx, busy, frame_done;

    int errors = 0;
    int checks = 0;
    int cyc;
    int busy_total = 0;
    int fd_total = 0;
    int fd_overlap = 0;
    bit dead = 1'b0;
    logic [7:0] byte_q[$];

    volt_uart_report #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .REPORT_CYCLES (REPORT_CYCLES)
    ) dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .ch1_dec    (ch1_dec),
        .ch1_sig    (ch1_sig),
        .report_en  (report_en),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 ad_clk = ~ad_clk;

    // Clock edges since reset release; sampled on negedges it equals the edge count.
    always @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge ad_clk) begin
        if (busy === 1'b1) busy_total++;
        if (frame_done === 1'b1) begin
            fd_total++;
            if (busy !== 1'b0) fd_overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push a 9-byte record, first byte in the top bits.
    task automatic push_record(input logic [71:0] rec);
        for (int i = 8; i >= 0; i--) byte_q.push_back(rec[i*8 +: 8]);
    endtask

    // Receive one byte off the line and compare against the scoreboard head.
    task automatic recv_byte(input string tag, output int start_cyc);
        logic [7:0] exp;
        logic [7:0] got;
        int waited;
        got = '0;
        waited = 0;
        start_cyc = -1;
        if (byte_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        exp = byte_q.pop_front();
        if (!dead) begin
            while (uart_tx !== 1'b0 && waited < WAIT_LIMIT) begin
                @(negedge ad_clk);
                waited++;
            end
        end
        if (dead || uart_tx !== 1'b0) begin
            dead = 1'b1;
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        start_cyc = cyc;
        repeat (BD / 2) @(negedge ad_clk);
        check({tag, "_start"}, 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge ad_clk);
            got[i] = uart_tx;
        end
`ifdef VOLT_UART_PARITY_EN
        repeat (BD) @(negedge ad_clk);
        check({tag, "_parity"}, 32'(uart_tx), 32'(^exp));
`endif
        repeat (BD) @(negedge ad_clk);
        check({tag, "_stop"}, 32'(uart_tx), 32'd1);
        check({tag, "_data"}, 32'(got), 32'(exp));
    endtask

    task automatic recv_frame(input string tag, output int start0);
        int s;
        start0 = -1;
        for (int i = 0; i < 9; i++) begin
            recv_byte($sformatf("%s_b%0d", tag, i), s);
            if (i == 0) start0 = s;
        end
    endtask

    initial begin
        int s0;
        int s;
        int b0;
        int f0;
        int low_cnt;
        int busy_cnt;

        // Reset state
        repeat (3) @(negedge ad_clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // 1: +4.998V, busy length, single frame_done
        ch1_sig = 8'd43;
        ch1_dec = 20'h04998;
        report_en = 1'b1;
        rst_n = 1'b1;
        b0 = busy_total;
        f0 = fd_total;
        push_record(72'h2B_34_2E_39_39_38_56_0D_0A);
        recv_frame("t1", s0);
        check("t1_start_cycle", 32'(s0), 32'(REPORT_CYCLES - 1 + 2));
        repeat (20) @(negedge ad_clk);
        check("t1_busy_cycles", 32'(busy_total - b0), 32'(9 * BYTE_CYC));
        check("t1_frame_done_pulses", 32'(fd_total - f0), 32'd1);

        // 2: negative sign, small value; start bit 2 cycles after second tick
        ch1_sig = 8'd45;
        ch1_dec = 20'h00002;
        push_record(72'h2D_30_2E_30_30_32_56_0D_0A);
        recv_frame("t2", s0);
        check("t2_start_cycle", 32'(s0), 32'(2 * REPORT_CYCLES - 1 + 2));

        // 3: invalid BCD digit shows as '?'
        ch1_sig = 8'd43;
        ch1_dec = 20'h012A4;
        push_record(72'h2B_31_2E_32_3F_34_56_0D_0A);
        recv_frame("t3", s0);
        check("t3_start_cycle", 32'(s0), 32'(3 * REPORT_CYCLES - 1 + 2));

        // 4: input change during byte 3 does not tear the record
        ch1_dec = 20'h01111;
        push_record(72'h2B_31_2E_31_31_31_56_0D_0A);
        for (int i = 0; i < 9; i++) begin
            recv_byte($sformatf("t4a_b%0d", i), s);
            if (i == 2) begin
                fork
                    begin
                        repeat (30) @(negedge ad_clk);
                        ch1_dec = 20'h02222;
                    end
                join_none
            end
        end
        push_record(72'h2B_32_2E_32_32_32_56_0D_0A);
        recv_frame("t4b", s0);
        check("t4b_start_cycle", 32'(s0), 32'(5 * REPORT_CYCLES - 1 + 2));

        // 5: reset mid-frame abandons the record immediately
        push_record(72'h2B_32_2E_32_32_32_56_0D_0A);
        for (int i = 0; i < 3; i++) recv_byte($sformatf("t5a_b%0d", i), s);
        repeat (15) @(negedge ad_clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_uart_tx", 32'(uart_tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_frame_done", 32'(frame_done), 32'd0);
        byte_q.delete();
        repeat (3) @(negedge ad_clk);
        rst_n = 1'b1;
        f0 = fd_total;
        push_record(72'h2B_32_2E_32_32_32_56_0D_0A);
        recv_frame("t5b", s0);
        check("t5b_start_cycle", 32'(s0), 32'(REPORT_CYCLES - 1 + 2));

        // 6: reporting disabled keeps the line idle for several periods
        report_en = 1'b0;
        repeat (20) @(negedge ad_clk);
        check("t5b_frame_done_pulses", 32'(fd_total - f0), 32'd1);
        low_cnt = 0;
        busy_cnt = 0;
        f0 = fd_total;
        repeat (3 * REPORT_CYCLES) begin
            @(negedge ad_clk);
            if (uart_tx !== 1'b1) low_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        check("t6_line_low_cycles", 32'(low_cnt), 32'd0);
        check("t6_busy_cycles", 32'(busy_cnt), 32'd0);
        check("t6_frame_done_pulses", 32'(fd_total - f0), 32'd0);
        check("frame_done_with_busy", 32'(fd_overlap), 32'd0);
        check("sb_drained", 32'(byte_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
